// File: rtl/spram_pkg.sv
// Shared types and parameter limits for the single-port RAM arbiter.
package spram_pkg;

  // Arbiter FSM: zero-fill sweep, then normal arbitration.
  typedef enum logic [0:0] {
    StInit,
    StRun
  } arb_state_e;

  localparam int unsigned NchMin   = 2;
  localparam int unsigned NchMax   = 8;
  localparam int unsigned RdLatMin = 1;
  localparam int unsigned RdLatMax = 3;

  // Round-robin successor of channel idx among n channels.
  function automatic int unsigned rr_next(int unsigned idx, int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/spram.sv
// Single-port synchronous RAM: write and registered read share one address.
module spram #(
  parameter int unsigned AW = 14,
  parameter int unsigned DW = 16
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] data_in,
  output logic [DW-1:0] data_out
);

  logic [DW-1:0] mem [2**AW];

  // Write on we; read data registered every cycle.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= data_in;
    end
    data_out <= mem[addr];
  end

endmodule

// File: rtl/spram_arbiter.sv
// Round-robin arbiter sharing one single-port RAM among NCH channels, with an
// optional zero-fill sweep after reset and a tagged read-return pipeline.
module spram_arbiter
  import spram_pkg::*;
#(
  parameter int unsigned NCH           = 2,
  parameter int unsigned AW            = 14,
  parameter int unsigned DW            = 16,
  parameter int unsigned RD_LAT        = 1,
  parameter bit          INIT_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NCH-1:0]    req,
  input  logic [NCH-1:0]    we,
  input  logic [NCH*AW-1:0] addr,
  input  logic [NCH*DW-1:0] wdata,
  output logic [NCH-1:0]    gnt,
  output logic [NCH-1:0]    rvalid,
  output logic [DW-1:0]     rdata,
  output logic              busy
);

  localparam int unsigned CW = $clog2(NCH);
  localparam arb_state_e ResetState = INIT_ON_RESET ? StInit : StRun;

  if (NCH < NchMin || NCH > NchMax) begin : g_bad_nch
    $error("spram_arbiter: NCH out of range");
  end
  if (RD_LAT < RdLatMin || RD_LAT > RdLatMax) begin : g_bad_lat
    $error("spram_arbiter: RD_LAT out of range");
  end

  arb_state_e state_q, state_d;
  logic [AW-1:0] init_cnt_q, init_cnt_d;
  logic [CW-1:0] ptr_q, ptr_d;
  logic [RD_LAT-1:0] tag_vld_q, tag_vld_d;
  logic [RD_LAT-1:0][CW-1:0] tag_ch_q, tag_ch_d;
  logic [DW-1:0] rdata_hold_q, rdata_hold_d;

  logic          gnt_any;
  logic [CW-1:0] gnt_idx;
  logic          rd_fire;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_dout;
  logic [DW-1:0] data_lat;
  int unsigned   cand;

  assign busy = (state_q == StInit);

  // Round-robin search starting at ptr_q; grants are combinational.
  always_comb begin
    gnt     = '0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    ptr_d   = ptr_q;
    cand    = 0;
    if (state_q == StRun) begin
      for (int unsigned i = 0; i < NCH; i++) begin
        cand = int'(ptr_q) + i;
        if (cand >= NCH) begin
          cand = cand - NCH;
        end
        if (!gnt_any && req[cand]) begin
          gnt_any   = 1'b1;
          gnt_idx   = CW'(cand);
          gnt[cand] = 1'b1;
          ptr_d     = CW'(rr_next(cand, NCH));
        end
      end
    end
  end

  // RAM port mux: the init sweep owns the port while busy.
  always_comb begin
    rd_fire = gnt_any && !we[gnt_idx];
    if (busy) begin
      mem_we    = 1'b1;
      mem_addr  = init_cnt_q;
      mem_wdata = '0;
    end else begin
      mem_we    = gnt_any && we[gnt_idx];
      mem_addr  = addr[gnt_idx*AW +: AW];
      mem_wdata = wdata[gnt_idx*DW +: DW];
    end
  end

  spram #(
    .AW(AW),
    .DW(DW)
  ) u_spram (
    .clk     (clk),
    .we      (mem_we),
    .addr    (mem_addr),
    .data_in (mem_wdata),
    .data_out(mem_dout)
  );

  // Extra data stages so read data lines up with the tag pipeline.
  if (RD_LAT == 1) begin : g_lat1
    assign data_lat = mem_dout;
  end else begin : g_latn
    logic [RD_LAT-2:0][DW-1:0] dpipe_q, dpipe_d;

    // Shift RAM output through RD_LAT-1 register stages.
    always_comb begin
      dpipe_d[0] = mem_dout;
      for (int unsigned i = 1; i < RD_LAT - 1; i++) begin
        dpipe_d[i] = dpipe_q[i-1];
      end
    end

    // Data stage registers.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        dpipe_q <= '0;
      end else begin
        dpipe_q <= dpipe_d;
      end
    end

    assign data_lat = dpipe_q[RD_LAT-2];
  end

  // Init sweep sequencing, tag pipeline and read-return outputs.
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    if (state_q == StInit) begin
      if (init_cnt_q == '1) begin
        state_d = StRun;
      end else begin
        init_cnt_d = init_cnt_q + 1'b1;
      end
    end

    tag_vld_d[0] = rd_fire;
    tag_ch_d[0]  = gnt_idx;
    for (int unsigned i = 1; i < RD_LAT; i++) begin
      tag_vld_d[i] = tag_vld_q[i-1];
      tag_ch_d[i]  = tag_ch_q[i-1];
    end

    rvalid = '0;
    rdata  = rdata_hold_q;
    if (tag_vld_q[RD_LAT-1]) begin
      rvalid[tag_ch_q[RD_LAT-1]] = 1'b1;
      rdata                      = data_lat;
    end
    rdata_hold_d = rdata;
  end

  // FSM and control state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ResetState;
      init_cnt_q   <= '0;
      ptr_q        <= '0;
      tag_vld_q    <= '0;
      tag_ch_q     <= '0;
      rdata_hold_q <= '0;
    end else begin
      state_q      <= state_d;
      init_cnt_q   <= init_cnt_d;
      ptr_q        <= ptr_d;
      tag_vld_q    <= tag_vld_d;
      tag_ch_q     <= tag_ch_d;
      rdata_hold_q <= rdata_hold_d;
    end
  end

endmodule

// File: tb/tb_spram_arbiter.sv
// Directed bench for spram_arbiter with default parameters (2 ch, AW=14, RD_LAT=1).
module tb_spram_arbiter;

  localparam int unsigned NCH = 2;
  localparam int unsigned AW  = 14;
  localparam int unsigned DW  = 16;
  localparam int unsigned INIT_CYCLES = 2**AW;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [NCH-1:0]    req = '0;
  logic [NCH-1:0]    we = '0;
  logic [NCH*AW-1:0] addr = '0;
  logic [NCH*DW-1:0] wdata = '0;
  logic [NCH-1:0]    gnt;
  logic [NCH-1:0]    rvalid;
  logic [DW-1:0]     rdata;
  logic              busy;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  spram_arbiter #(
    .NCH(NCH),
    .AW(AW),
    .DW(DW),
    .RD_LAT(1),
    .INIT_ON_RESET(1'b1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .we    (we),
    .addr  (addr),
    .wdata (wdata),
    .gnt   (gnt),
    .rvalid(rvalid),
    .rdata (rdata),
    .busy  (busy)
  );

  typedef struct {
    logic [1:0]  req;
    logic [1:0]  we;
    logic [13:0] a0;
    logic [13:0] a1;
    logic [15:0] d0;
    logic [15:0] d1;
    logic [1:0]  gnt;
    logic [1:0]  rvalid;
    logic [15:0] rdata;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] r, input logic [1:0] w, input logic [13:0] a0,
                       input logic [13:0] a1, input logic [15:0] d0, input logic [15:0] d1);
    req   = r;
    we    = w;
    addr  = {a1, a0};
    wdata = {d1, d0};
  endtask

  // Count cycles with busy high (req held on both channels), checking no grants.
  task automatic count_init(input string name);
    int n = 0;
    int gnt_seen = 0;
    drive(2'b11, 2'b00, 14'd0, 14'd0, 16'd0, 16'd0);
    while (busy && n < 20000) begin
      n++;
      if (gnt != 2'b00) gnt_seen++;
      @(negedge clk);
      #1;
    end
    req = '0;
    check({name, "_busy_cycles"}, n, INIT_CYCLES);
    check({name, "_gnt_during_init"}, gnt_seen, 0);
  endtask

  initial begin
    // Stimulus table: gnt is this cycle's combinational grant, rvalid/rdata the
    // registered return for reads granted in the previous row.
    vecs[0]  = '{2'b00, 2'b00, 14'd0, 14'd0, 16'd0,    16'd0, 2'b00, 2'b00, 16'd0};
    vecs[1]  = '{2'b01, 2'b01, 14'd1, 14'd0, 16'd4567, 16'd0, 2'b01, 2'b00, 16'd0};
    vecs[2]  = '{2'b01, 2'b00, 14'd1, 14'd0, 16'd0,    16'd0, 2'b01, 2'b00, 16'd0};
    vecs[3]  = '{2'b00, 2'b00, 14'd0, 14'd0, 16'd0,    16'd0, 2'b00, 2'b01, 16'd4567};
    vecs[4]  = '{2'b00, 2'b00, 14'd0, 14'd0, 16'd0,    16'd0, 2'b00, 2'b00, 16'd4567};
    vecs[5]  = '{2'b10, 2'b10, 14'd0, 14'd2, 16'd0,    16'd5, 2'b10, 2'b00, 16'd4567};
    vecs[6]  = '{2'b01, 2'b00, 14'd2, 14'd0, 16'd0,    16'd0, 2'b01, 2'b00, 16'd4567};
    vecs[7]  = '{2'b00, 2'b00, 14'd0, 14'd0, 16'd0,    16'd0, 2'b00, 2'b01, 16'd5};
    vecs[8]  = '{2'b11, 2'b00, 14'd5, 14'd1, 16'd0,    16'd0, 2'b10, 2'b00, 16'd5};
    vecs[9]  = '{2'b11, 2'b00, 14'd5, 14'd1, 16'd0,    16'd0, 2'b01, 2'b10, 16'd4567};
    vecs[10] = '{2'b11, 2'b00, 14'd5, 14'd1, 16'd0,    16'd0, 2'b10, 2'b01, 16'd0};
    vecs[11] = '{2'b11, 2'b00, 14'd5, 14'd1, 16'd0,    16'd0, 2'b01, 2'b10, 16'd4567};
    vecs[12] = '{2'b00, 2'b00, 14'd0, 14'd0, 16'd0,    16'd0, 2'b00, 2'b01, 16'd0};

    // Reset values.
    @(negedge clk);
    #1;
    check("rst_gnt", gnt, 0);
    check("rst_rvalid", rvalid, 0);
    check("rst_rdata", rdata, 0);
    check("rst_busy", busy, 1);
    reset = 1'b0;
    count_init("init1");

    // Table: write/read, hold, write-first, round-robin with reads, addr 5 reads 0.
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      drive(vecs[i].req, vecs[i].we, vecs[i].a0, vecs[i].a1, vecs[i].d0, vecs[i].d1);
      #1;
      check($sformatf("vec%0d_gnt", i), gnt, vecs[i].gnt);
      check($sformatf("vec%0d_rvalid", i), rvalid, vecs[i].rvalid);
      check($sformatf("vec%0d_rdata", i), rdata, vecs[i].rdata);
    end

    // Reset mid-sweep at init address 100; sweep restarts from 0.
    @(negedge clk);
    drive(2'b00, 2'b00, 14'd0, 14'd0, 16'd0, 16'd0);
    reset = 1'b1;
    #1;
    check("rst2_busy", busy, 1);
    @(negedge clk);
    reset = 1'b0;
    repeat (100) @(negedge clk);
    reset = 1'b1;
    #1;
    check("midinit_busy", busy, 1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    count_init("init2");

    // Continuous requests after reset alternate starting at ch0.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(2'b11, 2'b00, 14'd0, 14'd0, 16'd0, 16'd0);
      #1;
      check($sformatf("rr%0d_gnt", i), gnt, (i % 2 == 0) ? 2'b01 : 2'b10);
    end

    // Read in flight dropped by reset.
    @(negedge clk);
    drive(2'b01, 2'b01, 14'd1, 14'd0, 16'd4567, 16'd0);
    #1;
    check("drop_wr_gnt", gnt, 2'b01);
    @(negedge clk);
    drive(2'b01, 2'b00, 14'd1, 14'd0, 16'd0, 16'd0);
    #1;
    check("drop_rd_gnt", gnt, 2'b01);
    reset = 1'b1;
    #1;
    check("drop_rst_rvalid", rvalid, 0);
    check("drop_rst_rdata", rdata, 0);
    @(negedge clk);
    #1;
    check("drop_hold_rvalid", rvalid, 0);
    check("drop_hold_rdata", rdata, 0);
    reset = 1'b0;
    req   = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      check($sformatf("drop_after%0d_rvalid", i), rvalid, 0);
      check($sformatf("drop_after%0d_rdata", i), rdata, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
